// File: rtl/div_unit_if.sv
// Handshake and operand bus between the execute stage and the integer divider.
// master = execute stage, slave = divider.
interface div_unit_if #(
  parameter int XLEN = 64
);
  logic                div_valid;
  logic                div_32;
  logic                div_signed;
  logic                div_flush;
  logic [XLEN-1:0]     dividend;
  logic [XLEN-1:0]     divisor;
  logic                div_ready;
  logic [2*XLEN-1:0]   div_result;

  modport master (
    output div_valid, div_32, div_signed, div_flush, dividend, divisor,
    input  div_ready, div_result
  );

  modport slave (
    input  div_valid, div_32, div_signed, div_flush, dividend, divisor,
    output div_ready, div_result
  );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring radix-2 integer divider (RV64 DIV/DIVU/REM/REMU and W forms).
// Result is {remainder, quotient}; divide-by-zero and signed overflow skip the iteration.
//
// state | meaning
// IDLE  | waiting for a request; operands captured on acceptance
// BUSY  | one quotient bit per cycle, MSB first, counter counts down to 0
// DONE  | single cycle, div_ready asserted unless flushed
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic      clk,
  input  logic      rst,
  div_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-32){1'b0}}, 32'h8000_0000};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [XLEN-1:0]     dsr_q, dsr_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic                w32_q, w32_d;
  logic [2*XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]     a_sx, b_sx, a_zx, b_zx, a_mag, b_mag;
  logic                a_neg, b_neg, div_zero, ovf, fast, accept;
  logic [2*XLEN-1:0]   fast_res;

  logic [XLEN:0]       rem_sh, diff;
  logic                q_bit;
  logic [XLEN-1:0]     rem_nx, quo_nx, rem_s, quo_s;
  logic [2*XLEN-1:0]   fin_res;

  // Operand conditioning at the active width
  always_comb begin
    a_zx     = bus.div_32 ? {{(XLEN-32){1'b0}}, bus.dividend[31:0]} : bus.dividend;
    b_zx     = bus.div_32 ? {{(XLEN-32){1'b0}}, bus.divisor[31:0]}  : bus.divisor;
    a_sx     = bus.div_32 ? {{(XLEN-32){bus.dividend[31]}}, bus.dividend[31:0]} : bus.dividend;
    b_sx     = bus.div_32 ? {{(XLEN-32){bus.divisor[31]}}, bus.divisor[31:0]}   : bus.divisor;
    a_neg    = bus.div_signed & a_sx[XLEN-1];
    b_neg    = bus.div_signed & b_sx[XLEN-1];
    a_mag    = a_neg ? -a_sx : a_zx;
    b_mag    = b_neg ? -b_sx : b_zx;
    div_zero = (b_zx == '0);
    ovf      = bus.div_signed & (a_zx == (bus.div_32 ? MIN_W : MIN_X)) & (b_sx == '1);
    fast     = div_zero | ovf;
    fast_res = div_zero ? {a_sx, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_sx};
    accept   = (state_q == IDLE) & bus.div_valid & ~bus.div_flush;
  end

  // One restoring step plus final sign fix-up
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    diff    = rem_sh - {1'b0, dsr_q};
    q_bit   = ~diff[XLEN];
    rem_nx  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], q_bit};
    quo_s   = neg_quo_q ? -quo_nx : quo_nx;
    rem_s   = neg_rem_q ? -rem_nx : rem_nx;
    fin_res = w32_q ? {{(XLEN-32){rem_s[31]}}, rem_s[31:0], {(XLEN-32){quo_s[31]}}, quo_s[31:0]}
                    : {rem_s, quo_s};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = fast ? DONE : BUSY;
      BUSY:    if (bus.div_flush) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.div_ready  = (state_q == DONE) & ~bus.div_flush;
    bus.div_result = result_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    w32_d     = w32_q;
    result_d  = result_q;
    if (accept) begin
      cnt_d     = bus.div_32 ? CW'(32) : CW'(XLEN);
      rem_d     = '0;
      // Word operands start at the top so the MSB-first shift sees bit 31 first
      quo_d     = bus.div_32 ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
      dsr_d     = b_mag;
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      w32_d     = bus.div_32;
      if (fast) result_d = fast_res;
    end else if (state_q == BUSY && !bus.div_flush) begin
      cnt_d = cnt_q - CW'(1);
      rem_d = rem_nx;
      quo_d = quo_nx;
      if (cnt_q == CW'(1)) result_d = fin_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      w32_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      w32_q     <= w32_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: arithmetic reference model plus literal pins.
module tb_div_unit;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_unit_if #(.XLEN(XLEN)) bus ();
  div_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           exp_valid = 1'b0;
  int           exp_cycle = 0;
  int           acc_cyc   = 0;
  logic [127:0] exp_res   = '0;
  logic [127:0] last_res  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference: language-level division with the RISC-V special cases
  function automatic void model(input bit w32, input bit sgn, input logic [63:0] a,
                                input logic [63:0] b, output logic [127:0] res, output int lat);
    longint sa, sb;
    longint unsigned ua, ub;
    int sa32, sb32;
    int unsigned ua32, ub32;
    logic [63:0] q, r;
    logic [31:0] q32, r32;
    if (!w32) begin
      lat = 0;
      if (b == 64'd0) begin
        q = '1; r = a;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = '0;
      end else begin
        lat = 64;
        if (sgn) begin sa = a; sb = b; q = sa / sb; r = sa % sb; end
        else     begin ua = a; ub = b; q = ua / ub; r = ua % ub; end
      end
      res = {r, q};
    end else begin
      lat = 0;
      if (b[31:0] == 32'd0) begin
        q32 = '1; r32 = a[31:0];
      end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = '0;
      end else begin
        lat = 32;
        if (sgn) begin sa32 = a[31:0]; sb32 = b[31:0]; q32 = sa32 / sb32; r32 = sa32 % sb32; end
        else     begin ua32 = a[31:0]; ub32 = b[31:0]; q32 = ua32 / ub32; r32 = ua32 % ub32; end
      end
      res = {{32{r32[31]}}, r32, {32{q32[31]}}, q32};
    end
  endfunction

  // Per-cycle compare: ready only on the predicted cycle, result stable otherwise
  always @(negedge clk) begin
    logic exp_rdy;
    if (!rst) begin
      last_res = '0;
    end else begin
      exp_rdy = exp_valid && (cyc == exp_cycle);
      check("ready", {127'd0, bus.div_ready}, {127'd0, exp_rdy});
      if (exp_rdy) begin
        check("result", bus.div_result, exp_res);
        last_res = exp_res;
      end else begin
        check("hold", bus.div_result, last_res);
      end
    end
  end

  task automatic issue(input bit w32, input bit sgn, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m;
    int l;
    model(w32, sgn, a, b, m, l);
    @(negedge clk);
    bus.div_flush  = 1'b0;
    bus.div_valid  = 1'b1;
    bus.div_32     = w32;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    exp_res   = m;
    exp_cycle = cyc + l;
    exp_valid = 1'b1;
    // Stage keeps valid high but forwards something else; must not matter
    bus.dividend   = {$urandom, $urandom};
    bus.divisor    = {$urandom, $urandom};
    bus.div_32     = ~w32;
    bus.div_signed = ~sgn;
  endtask

  task automatic wait_ready(input int drop_at, output int lat, output logic [127:0] res);
    lat = -1;
    res = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == drop_at) bus.div_valid = 1'b0;
      if (bus.div_ready) begin
        lat = cyc - acc_cyc + 1;
        res = bus.div_result;
        bus.div_valid = 1'b0;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      $display("FAIL timeout: no div_ready within 100 cycles, required one");
    end
  endtask

  task automatic run_lit(input string name, input bit w32, input bit sgn, input logic [63:0] a,
                         input logic [63:0] b, input int lat_req, input logic [127:0] res_req);
    int l;
    logic [127:0] r;
    issue(w32, sgn, a, b);
    wait_ready(-1, l, r);
    check({name, "_lat"}, l, lat_req);
    check({name, "_res"}, r, res_req);
  endtask

  task automatic run_model(input bit w32, input bit sgn, input logic [63:0] a,
                           input logic [63:0] b, input int drop_at);
    int l;
    logic [127:0] r;
    issue(w32, sgn, a, b);
    wait_ready(drop_at, l, r);
  endtask

  localparam int NV = 11;
  bit          v_w32 [NV] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
  bit          v_sgn [NV] = '{1, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1};
  logic [63:0] v_a   [NV] = '{64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'h8000_0000_0000_0000,
                              64'hDEAD_BEEF_CAFE_BABE, 64'd3, 64'h1234_5678_FFFF_FFF0,
                              64'h0000_0000_8000_0001, 64'h0000_0000_8000_0005,
                              64'hAAAA_AAAA_7FFF_FFFF, 64'h0000_0000_FFFF_FF9C,
                              64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] v_b   [NV] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0001_2345, 64'd10,
                              64'd3, 64'd1, 64'd0, 64'h5555_0000_0000_0000, 64'd7,
                              64'h8000_0000_0000_0000};

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.div_valid  = 1'b0;
    bus.div_32     = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_flush  = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {127'd0, bus.div_ready}, 128'd0);
    check("rst_result", bus.div_result, 128'd0);
    rst = 1'b1;

    run_lit("s64_100_7", 0, 1, 64'd100, 64'd7, 65, {64'd2, 64'd14});
    run_lit("s64_m100_7", 0, 1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 65,
            {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2});
    run_lit("u64_max_2", 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 65,
            {64'd1, 64'h7FFF_FFFF_FFFF_FFFF});
    run_lit("w_ovf", 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
            {64'd0, 64'hFFFF_FFFF_8000_0000});
    run_lit("div0", 0, 0, 64'd5, 64'd0, 1, {64'd5, 64'hFFFF_FFFF_FFFF_FFFF});

    for (int i = 0; i < NV; i++) run_model(v_w32[i], v_sgn[i], v_a[i], v_b[i], -1);
    run_model(0, 1, 64'd12345, 64'hFFFF_FFFF_FFFF_FFBD, 5);

    // Flush mid-divide, then flush held against a pending request in IDLE
    issue(0, 1, 64'd1000, 64'd3);
    repeat (10) @(negedge clk);
    bus.div_flush = 1'b1;
    bus.div_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    @(posedge clk);
    run_lit("flush_w9_4", 1, 0, 64'd9, 64'd4, 33, {64'd1, 64'd2});

    issue(0, 0, 64'd77777, 64'd5);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    exp_valid = 1'b0;
    bus.div_valid = 1'b0;
    #1;
    check("rst_mid_ready", {127'd0, bus.div_ready}, 128'd0);
    check("rst_mid_result", bus.div_result, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_lit("rst_w9_4", 1, 0, 64'd9, 64'd4, 33, {64'd1, 64'd2});

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 64: operand width; 32-bit (word) mode uses bits [31:0] only.
REQ-002 clk  input  1  rising-edge clock; all state updates on it.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 div_valid  input  1  divide request from the execute stage, held high while that stage stalls.
REQ-005 div_32  input  1  word mode (DIVW/REMW family); sampled with div_valid.
REQ-006 div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); sampled with div_valid.
REQ-007 div_flush  input  1  pipeline flush; cancels any operation in progress.
REQ-008 dividend  input  XLEN  rs1 operand after forwarding.
REQ-009 divisor  input  XLEN  rs2 operand after forwarding.
REQ-010 div_ready  output  1  one-cycle pulse; div_result is valid in that cycle.
REQ-011 div_result  output  2*XLEN  {remainder, quotient}; quotient in [63:0], remainder in [127:64].

Function
REQ-012 States: IDLE, BUSY, DONE. div_ready SHALL be high only in DONE with div_flush low.
REQ-013 IDLE, div_valid=1 and div_flush=0 at edge T: latch magnitudes, result signs, mode and divisor; clear the partial remainder; load the iteration counter N (64, or 32 when div_32=1).
REQ-014 Signed mode: the magnitude of each operand is its two's complement absolute value. Word mode: operands are bits [31:0], sign-extended (signed) or zero-extended (unsigned) to 33 bits.
REQ-015 BUSY: restoring radix-2 division, one quotient bit per cycle, MSB first. The counter decrements each cycle. On the cycle it reaches 0, go to DONE.
REQ-016 Normal latency: the operation is accepted at edge T, and div_ready is high in the cycle following edge T+N (N+1 cycles after acceptance: 65 for 64-bit, 33 for word).
REQ-017 Fast path: divisor zero, or signed overflow (most-negative / -1 at the active width), SHALL skip BUSY; div_ready is high in the cycle after acceptance.
REQ-018 Divide by zero: quotient all ones; remainder equals the dividend.
REQ-019 Signed overflow: quotient equals the dividend; remainder is 0.
REQ-020 Signed results: quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
REQ-021 Word mode: quotient in [31:0] and remainder in [95:64]. Bits [63:32] and [127:96] are the sign extension of bit 31 and bit 95 respectively, for both signed and unsigned.
REQ-022 DONE lasts exactly one cycle and then returns to IDLE. div_valid is ignored in DONE. A new request is accepted in IDLE the next cycle, so back-to-back divides are allowed.
REQ-023 div_result is registered and holds its value from DONE until the next result is written; it does not change during BUSY.
REQ-024 div_flush=1 in any state: next state is IDLE with no div_ready pulse; div_result keeps its prior value. Flush overrides a simultaneous div_valid in IDLE.
REQ-025 div_valid dropping during BUSY without a flush is a protocol violation; the operation SHALL still complete.
REQ-026 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-027 When rst is low: state = IDLE, div_ready = 0, div_result = 0, counter = 0, and all datapath registers are cleared, immediately and independent of clk.
REQ-028 If reset is deasserted mid-operation, the cancelled operation SHALL NOT produce a div_ready pulse.

Verification
REQ-029 Signed 64-bit, 100 / 7 -> div_ready 65 cycles after acceptance; quotient 14, remainder 2.
REQ-030 Signed 64-bit, -100 / 7 -> quotient 0xFFFFFFFFFFFFFFF2, remainder 0xFFFFFFFFFFFFFFFE.
REQ-031 Unsigned, 0xFFFFFFFFFFFFFFFF / 2 -> quotient 0x7FFFFFFFFFFFFFFF, remainder 1.
REQ-032 Word signed, 0x80000000 / 0xFFFFFFFF -> div_ready 1 cycle after acceptance; [63:0] = 0xFFFFFFFF80000000, [127:64] = 0.
REQ-033 64-bit, 5 / 0 -> div_ready 1 cycle after acceptance; quotient all ones, remainder 5.
REQ-034 Flush 10 cycles into a 64-bit divide -> no div_ready; IDLE next cycle; a following word 9 / 4 gives quotient 2, remainder 1, 33 cycles after acceptance. The same outcome SHALL hold when rst is pulsed low mid-operation instead of the flush.
